// File: rtl/ex_to_mem_reg_pkg.sv
// Shared pipeline-register definitions.
//  XLEN_DEF / RD_W_DEF : default datapath and register-index widths
//  CTRL_W              : width of the {ld, str, we} control bundle
//  pipe_ctrl_t         : the control bundle itself, shared by all stage registers
//  gate_ctrl()         : forces the control bundle to zero for an invalid entry
package ex_to_mem_reg_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RD_W_DEF = 5;
  localparam int CTRL_W   = 3;

  typedef struct packed {
    logic ld;
    logic str;
    logic we;
  } pipe_ctrl_t;

  // A bubble must never write registers or memory, whatever the held bits say.
  function automatic pipe_ctrl_t gate_ctrl(input pipe_ctrl_t ctrl, input logic valid);
    return valid ? ctrl : pipe_ctrl_t'('0);
  endfunction

endpackage

// File: rtl/ex_to_mem_reg_if.sv
// Valid/ready stage bus carrying one EX result beat.
//  valid, alu_out, b2, rd, ld, str, we : driven by the producer (master)
//  ready                              : driven by the consumer (slave)
interface ex_to_mem_reg_if
  import ex_to_mem_reg_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RD_W = RD_W_DEF
);

  logic            valid;
  logic            ready;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] b2;
  logic [RD_W-1:0] rd;
  logic            ld;
  logic            str;
  logic            we;

  modport master (output valid, alu_out, b2, rd, ld, str, we, input ready);
  modport slave  (input valid, alu_out, b2, rd, ld, str, we, output ready);

endinterface

// File: rtl/ex_to_mem_reg_pipe_entry.sv
// One pipeline-register slot: valid bit, data word and control bundle.
//  clk, rst  : clock, synchronous active-high reset
//  clear     : drop the entry (valid and control cleared, data kept)
//  load      : take d_valid; data/ctrl are captured only for a valid beat
//  d_*       : next contents
//  q_*       : current contents, control gated to zero when invalid
module ex_to_mem_reg_pipe_entry
  import ex_to_mem_reg_pkg::*;
#(
  parameter int DATA_W = 2 * XLEN_DEF + RD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              d_valid,
  input  logic [DATA_W-1:0] d_data,
  input  pipe_ctrl_t        d_ctrl,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output pipe_ctrl_t        q_ctrl
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  pipe_ctrl_t        ctrl_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering; the data word is reset as
  // well so MEM_* reads as zero straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load) begin
      valid_q <= d_valid;
      if (d_valid) begin
        data_q <= d_data;
        ctrl_q <= d_ctrl;
      end else begin
        ctrl_q <= '0;
      end
    end
  end

  assign q_valid = valid_q;
  assign q_data  = data_q;
  assign q_ctrl  = gate_ctrl(ctrl_q, valid_q);

endmodule

// File: rtl/ex_to_mem_reg.sv
// Elastic EX->MEM pipeline register with a one-entry skid buffer.
//  clk, rst : clock, synchronous active-high reset (wins over flush)
//  flush    : kill both held entries and the incoming EX beat
//  ex       : upstream bus from EX (slave side); ex.ready is a pure flop output
//  mem      : downstream bus to MEM (master side)
// The skid slot only fills when main is held by a stalled MEM, so the number of
// beats in flight is 0, 1 (main) or 2 (main + skid); ready drops only at 2.
module ex_to_mem_reg
  import ex_to_mem_reg_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RD_W = RD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  ex_to_mem_reg_if.slave    ex,
  ex_to_mem_reg_if.master   mem
);

  localparam int DATA_W = 2 * XLEN + RD_W;

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data,  skid_data;
  pipe_ctrl_t        main_ctrl,  skid_ctrl;

  logic              accept, drain;
  logic              main_load, main_d_valid;
  logic [DATA_W-1:0] main_d_data;
  pipe_ctrl_t        main_d_ctrl;
  logic              skid_capture, skid_release;

  logic [DATA_W-1:0] ex_data;
  pipe_ctrl_t        ex_ctrl;

  assign ex_data = {ex.alu_out, ex.b2, ex.rd};
  assign ex_ctrl = '{ld: ex.ld, str: ex.str, we: ex.we};

  // Ready comes straight from the skid flop: no EX_valid or MEM_ready path.
  assign ex.ready = !skid_valid;
  assign accept   = ex.valid & !skid_valid & !flush;
  assign drain    = main_valid & mem.ready;

  // Main refills whenever it is empty or its beat leaves; the older skid beat
  // always goes ahead of the current EX beat to keep order.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    main_load    = !main_valid | drain;
    main_d_valid = 1'b0;
    main_d_data  = ex_data;
    main_d_ctrl  = ex_ctrl;
    if (skid_valid) begin
      main_d_valid = 1'b1;
      main_d_data  = skid_data;
      main_d_ctrl  = skid_ctrl;
    end else if (accept) begin
      main_d_valid = 1'b1;
    end
  end

  // Capture and release are exclusive: capture needs an empty skid slot.
  assign skid_capture = accept & main_valid & !mem.ready;
  assign skid_release = skid_valid & (drain | !main_valid);

  ex_to_mem_reg_pipe_entry #(.DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .load    (main_load),
    .d_valid (main_d_valid),
    .d_data  (main_d_data),
    .d_ctrl  (main_d_ctrl),
    .q_valid (main_valid),
    .q_data  (main_data),
    .q_ctrl  (main_ctrl)
  );

  ex_to_mem_reg_pipe_entry #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .load    (skid_capture | skid_release),
    .d_valid (skid_capture),
    .d_data  (ex_data),
    .d_ctrl  (ex_ctrl),
    .q_valid (skid_valid),
    .q_data  (skid_data),
    .q_ctrl  (skid_ctrl)
  );

  assign mem.valid   = main_valid;
  assign mem.alu_out = main_data[DATA_W-1 -: XLEN];
  assign mem.b2      = main_data[RD_W +: XLEN];
  assign mem.rd      = main_data[RD_W-1:0];
  assign mem.ld      = main_ctrl.ld;
  assign mem.str     = main_ctrl.str;
  assign mem.we      = main_ctrl.we;

endmodule

// File: tb/tb_ex_to_mem_reg.sv
// Directed and randomized checks for the EX->MEM elastic pipeline register.
module tb_ex_to_mem_reg;
  import ex_to_mem_reg_pkg::*;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] b2;
    logic [4:0]  rd;
    logic        ld;
    logic        str;
    logic        we;
  } beat_t;

  // {mem.valid, mem.ld, mem.str, mem.we, ex.ready}
  typedef logic [4:0] ctl_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ex_to_mem_reg_if #(.XLEN(32), .RD_W(5)) ex_bus ();
  ex_to_mem_reg_if #(.XLEN(32), .RD_W(5)) mem_bus ();

  ex_to_mem_reg #(.XLEN(32), .RD_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .ex    (ex_bus),
    .mem   (mem_bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] alu, input logic [31:0] b2,
                          input logic [4:0] rd, input logic ld, input logic str, input logic we);
    ex_bus.valid   = v;
    ex_bus.alu_out = alu;
    ex_bus.b2      = b2;
    ex_bus.rd      = rd;
    ex_bus.ld      = ld;
    ex_bus.str     = str;
    ex_bus.we      = we;
  endtask

  function automatic beat_t mem_beat();
    return '{alu: mem_bus.alu_out, b2: mem_bus.b2, rd: mem_bus.rd,
             ld: mem_bus.ld, str: mem_bus.str, we: mem_bus.we};
  endfunction

  function automatic ctl_t ctl_view();
    return {mem_bus.valid, mem_bus.ld, mem_bus.str, mem_bus.we, ex_bus.ready};
  endfunction

  function automatic beat_t mk(input logic [31:0] alu, input logic [31:0] b2, input logic [4:0] rd,
                               input logic ld, input logic str, input logic we);
    return '{alu: alu, b2: b2, rd: rd, ld: ld, str: str, we: we};
  endfunction

  task automatic test_reset();
    beat_t exp_b;
    flush = 1'b0;
    mem_bus.ready = 1'b0;
    drive_ex(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd9, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl_view() !== 5'b0000_1) begin
      failures++;
      $display("FAIL reset_ctl: got %b expected %b", ctl_view(), 5'b0000_1);
    end
    exp_b = mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mem_beat() !== exp_b) begin
      failures++;
      $display("FAIL reset_data: got %h expected %h", mem_beat(), exp_b);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] vals [3];
    beat_t exp_b;
    vals[0] = 32'h10; vals[1] = 32'h20; vals[2] = 32'h30;
    mem_bus.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_ex(1'b1, vals[i], 32'h100 + i, 5'd1, 1'b0, 1'b0, 1'b1);
      step();
      exp_b = mk(vals[i], 32'h100 + i, 5'd1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (ctl_view() !== 5'b1001_1 || mem_beat() !== exp_b) begin
        failures++;
        $display("FAIL stream_%0d: got ctl=%b beat=%h expected ctl=%b beat=%h",
                 i, ctl_view(), mem_beat(), 5'b1001_1, exp_b);
      end
    end
    drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (ctl_view() !== 5'b0000_1) begin
      failures++;
      $display("FAIL stream_drain: got %b expected %b", ctl_view(), 5'b0000_1);
    end
  endtask

  task automatic test_backpressure();
    beat_t exp_b;
    mem_bus.ready = 1'b0;
    drive_ex(1'b1, 32'hA, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1);
    step();
    drive_ex(1'b1, 32'hB, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1);
    step();
    exp_b = mk(32'hA, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ctl_view() !== 5'b1001_0 || mem_beat() !== exp_b) begin
      failures++;
      $display("FAIL bp_full: got ctl=%b beat=%h expected ctl=%b beat=%h",
               ctl_view(), mem_beat(), 5'b1001_0, exp_b);
    end
    // 0xC is held by EX while the block is full.
    drive_ex(1'b1, 32'hC, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1);
    step();
    checks++;
    if (ctl_view() !== 5'b1001_0 || mem_beat() !== exp_b) begin
      failures++;
      $display("FAIL bp_stall_stable: got ctl=%b beat=%h expected ctl=%b beat=%h",
               ctl_view(), mem_beat(), 5'b1001_0, exp_b);
    end
    mem_bus.ready = 1'b1;
    step();
    exp_b = mk(32'hB, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ctl_view() !== 5'b1001_1 || mem_beat() !== exp_b) begin
      failures++;
      $display("FAIL bp_second: got ctl=%b beat=%h expected ctl=%b beat=%h",
               ctl_view(), mem_beat(), 5'b1001_1, exp_b);
    end
    step();
    exp_b = mk(32'hC, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ctl_view() !== 5'b1001_1 || mem_beat() !== exp_b) begin
      failures++;
      $display("FAIL bp_third: got ctl=%b beat=%h expected ctl=%b beat=%h",
               ctl_view(), mem_beat(), 5'b1001_1, exp_b);
    end
    drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (ctl_view() !== 5'b0000_1) begin
      failures++;
      $display("FAIL bp_empty: got %b expected %b", ctl_view(), 5'b0000_1);
    end
  endtask

  task automatic test_flush();
    mem_bus.ready = 1'b0;
    drive_ex(1'b1, 32'h55, 32'hAA, 5'd2, 1'b0, 1'b1, 1'b0);
    step();
    drive_ex(1'b1, 32'h66, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1);
    step();
    checks++;
    if (ctl_view() !== 5'b1010_0) begin
      failures++;
      $display("FAIL flush_pre_full: got %b expected %b", ctl_view(), 5'b1010_0);
    end
    drive_ex(1'b1, 32'h77, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (ctl_view() !== 5'b0000_1) begin
      failures++;
      $display("FAIL flush_full: got %b expected %b", ctl_view(), 5'b0000_1);
    end
    drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    mem_bus.ready = 1'b1;
    step();
    checks++;
    if (ctl_view() !== 5'b0000_1) begin
      failures++;
      $display("FAIL flush_no_emit: got %b expected %b", ctl_view(), 5'b0000_1);
    end
    // Flush while ready=1 must also kill the incoming EX beat.
    mem_bus.ready = 1'b0;
    drive_ex(1'b1, 32'h81, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1);
    step();
    drive_ex(1'b1, 32'h88, 32'h0, 5'd8, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    mem_bus.ready = 1'b1;
    step();
    checks++;
    if (ctl_view() !== 5'b0000_1) begin
      failures++;
      $display("FAIL flush_kills_ex: got %b expected %b", ctl_view(), 5'b0000_1);
    end
  endtask

  task automatic test_bubble();
    mem_bus.ready = 1'b1;
    drive_ex(1'b1, 32'h44, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1);
    step();
    checks++;
    if (ctl_view() !== 5'b1001_1 || mem_bus.alu_out !== 32'h44) begin
      failures++;
      $display("FAIL bubble_pre: got ctl=%b alu=%h expected ctl=%b alu=%h",
               ctl_view(), mem_bus.alu_out, 5'b1001_1, 32'h44);
    end
    drive_ex(1'b0, 32'h45, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1);
    step();
    checks++;
    if (ctl_view() !== 5'b0000_1) begin
      failures++;
      $display("FAIL bubble_we: got %b expected %b", ctl_view(), 5'b0000_1);
    end
  endtask

  task automatic test_reset_mid_stall();
    mem_bus.ready = 1'b0;
    drive_ex(1'b1, 32'h91, 32'h1, 5'd1, 1'b1, 1'b0, 1'b1);
    step();
    drive_ex(1'b1, 32'h92, 32'h2, 5'd2, 1'b0, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl_view() !== 5'b0000_1 || mem_bus.alu_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_stall: got ctl=%b alu=%h expected ctl=%b alu=%h",
               ctl_view(), mem_bus.alu_out, 5'b0000_1, 32'h0);
    end
    mem_bus.ready = 1'b1;
    step();
    checks++;
    if (ctl_view() !== 5'b0000_1) begin
      failures++;
      $display("FAIL reset_no_emit: got %b expected %b", ctl_view(), 5'b0000_1);
    end
  endtask

  task automatic test_random();
    beat_t q[$];
    beat_t cur;
    logic  pending;
    logic  acc, drn;
    pending = 1'b0;
    cur = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      checks++;
      if (ex_bus.ready !== (q.size() < 2)) begin
        failures++;
        $display("FAIL rand_ready cyc=%0d: got %b expected %b", cyc, ex_bus.ready, q.size() < 2);
      end
      checks++;
      if (mem_bus.valid !== (q.size() != 0)) begin
        failures++;
        $display("FAIL rand_valid cyc=%0d: got %b expected %b", cyc, mem_bus.valid, q.size() != 0);
      end
      checks++;
      if (q.size() != 0) begin
        if (mem_beat() !== q[0]) begin
          failures++;
          $display("FAIL rand_beat cyc=%0d: got %h expected %h", cyc, mem_beat(), q[0]);
        end
      end else if ({mem_bus.ld, mem_bus.str, mem_bus.we} !== 3'b000) begin
        failures++;
        $display("FAIL rand_bubble_ctrl cyc=%0d: got %b expected %b",
                 cyc, {mem_bus.ld, mem_bus.str, mem_bus.we}, 3'b000);
      end

      if (!pending && $urandom_range(0, 3) != 0) begin
        cur.alu = $urandom();
        cur.b2  = $urandom();
        cur.rd  = 5'($urandom_range(0, 31));
        cur.ld  = 1'($urandom_range(0, 1));
        cur.str = 1'($urandom_range(0, 1));
        cur.we  = 1'($urandom_range(0, 1));
        pending = 1'b1;
      end
      drive_ex(pending, cur.alu, cur.b2, cur.rd, cur.ld, cur.str, cur.we);
      mem_bus.ready = ($urandom_range(0, 2) != 0);

      acc = pending && (q.size() < 2);
      drn = (q.size() != 0) && mem_bus.ready;
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(cur);
        pending = 1'b0;
      end
      step();
    end
    drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    mem_bus.ready = 1'b0;
    drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
